// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between two valid/ready requesters,
// with a single-stage registered output buffer and a bounded per-port grant run.
module mux2_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

  state_t     state_q, state_d;
  logic       last_q;
  logic [3:0] hold_q, hold_d;
  logic       load_en, gnt, xfer, sel_d;
  logic [1:0] vld;

  assign vld     = {in1_valid, in0_valid};
  assign load_en = !out_valid || out_ready;
  // index of the port owning the mux while in a grant state
  assign gnt     = (state_q == GRANT1);
  assign xfer    = (state_q != IDLE) && vld[gnt] && load_en;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (&vld)           state_d = last_q ? GRANT0 : GRANT1;
        else if (in0_valid) state_d = GRANT0;
        else if (in1_valid) state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        in0_ready = !gnt && load_en;
        in1_ready = gnt && load_en;
        if (xfer) begin
          // run limit: hand over only if the other side is actually waiting
          if (hold_q == 4'(HOLD_MAX - 1)) begin
            hold_d = '0;
            if (vld[!gnt]) state_d = gnt ? GRANT0 : GRANT1;
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end else if (!vld[gnt]) begin
          hold_d  = '0;
          state_d = vld[!gnt] ? (gnt ? GRANT0 : GRANT1) : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // select follows the grant, holds while idle
  always_comb begin
    sel_d = sel;
    if (state_d == GRANT0)      sel_d = 1'b1;
    else if (state_d == GRANT1) sel_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      last_q    <= 1'b1;
      sel       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sel     <= sel_d;
      if (xfer) begin
        out_data  <= sel ? in0_data : in1_data;
        out_valid <= 1'b1;
        last_q    <= gnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios plus a random phase checked by
// an acceptance-order scoreboard and a grant-run fairness bound.
module tb_mux2_rr_arbiter;
  localparam int WIDTH = 8;
  localparam int HOLD_MAX = 4;

  logic             clk, reset;
  logic [WIDTH-1:0] in0_data, in1_data, out_data;
  logic             in0_valid, in0_ready, in1_valid, in1_ready;
  logic             out_valid, out_ready, sel;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .reset(reset),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel(sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc_n = 0;
  int run_port = -1, run_cnt = 0, pushed = 0;
  logic [7:0] q0[$], q1[$], exp_q[$], outs[$], e[$];
  int out_cyc[$];
  bit en0 = 0, en1 = 0, ordy = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // consecutive grants to one port while the other waits must not exceed HOLD_MAX
  task automatic fair(input int k, input logic other_v);
    if (other_v) begin
      if (run_port == k) run_cnt++;
      else begin run_port = k; run_cnt = 1; end
      chk("fair_hold", run_cnt <= HOLD_MAX, 1);
    end else begin
      run_port = -1; run_cnt = 0;
    end
  endtask

  task automatic step();
    logic [7:0] d;
    @(negedge clk);
    in0_valid = en0 && (q0.size() > 0);
    if (in0_valid) in0_data = q0[0]; else in0_data = 8'($urandom);
    in1_valid = en1 && (q1.size() > 0);
    if (in1_valid) in1_data = q1[0]; else in1_data = 8'($urandom);
    out_ready = ordy;
    #1;
    chk("out_valid", out_valid, exp_q.size() > 0);
    if (out_valid && exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
    chk("one_ready", in0_ready & in1_ready, 0);
    if (out_valid && out_ready) begin
      outs.push_back(out_data);
      out_cyc.push_back(cyc_n);
      if (exp_q.size() > 0) d = exp_q.pop_front();
    end
    if (in0_valid && in0_ready) begin
      d = q0.pop_front(); exp_q.push_back(d); fair(0, in1_valid);
    end
    if (in1_valid && in1_ready) begin
      d = q1.pop_front(); exp_q.push_back(d); fair(1, in0_valid);
    end
    cyc_n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    en0 = 0; en1 = 0; ordy = 1;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    q0.delete(); q1.delete(); exp_q.delete(); outs.delete(); out_cyc.delete();
    run_port = -1; run_cnt = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sel", sel, 0);
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int g = 0;
    while (outs.size() < n && g < budget) begin step(); g++; end
    chk({tag, "_done"}, outs.size() >= n, 1);
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_count"}, outs.size(), e.size());
    for (int i = 0; i < e.size() && i < outs.size(); i++) chk(tag, outs[i], e[i]);
  endtask

  initial begin
    int s, g;
    reset = 1'b1; in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0; out_ready = 1;

    // 1: single stream, no switch at the run limit, idle afterwards
    do_reset();
    for (int i = 0; i < 6; i++) q0.push_back(8'(8'h10 + i));
    en0 = 1; s = cyc_n;
    run_until("t1", 6, 40);
    e = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    chk_seq("t1_data");
    if (out_cyc.size() >= 6) begin
      chk("t1_latency", out_cyc[0] - s, 2);
      chk("t1_span", out_cyc[5] - out_cyc[0], 5);
    end
    step();
    chk("t6_idle_ready", in0_ready, 0);
    chk("t6_sel_hold", sel, 1);
    chk("t6_out_valid", out_valid, 0);

    // 2: both valid from idle, alternate in runs of HOLD_MAX
    do_reset();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(8'(8'hA0 + i)); q1.push_back(8'(8'hB0 + i));
    end
    en0 = 1; en1 = 1;
    run_until("t2", 16, 60);
    e.delete();
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < HOLD_MAX; j++)
        e.push_back(8'(((b % 2) ? 8'hB0 : 8'hA0) + (b / 2) * HOLD_MAX + j));
    chk_seq("t2_data");
    if (out_cyc.size() >= 16) chk("t2_span", out_cyc[15] - out_cyc[0], 15);

    // 3: backpressure freezes output and does not advance the run count
    do_reset();
    for (int i = 0; i < 8; i++) q0.push_back(8'(8'h20 + i));
    for (int i = 0; i < 4; i++) q1.push_back(8'(8'h30 + i));
    en0 = 1; en1 = 1;
    run_until("t3a", 2, 20);
    ordy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_in0_ready", in0_ready, 0);
      chk("t3_out_valid", out_valid, 1);
      chk("t3_out_frozen", out_data, 8'h22);
    end
    ordy = 1;
    run_until("t3b", 12, 40);
    e = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33,
          8'h24, 8'h25, 8'h26, 8'h27};
    chk_seq("t3_data");

    // 4: granted port drops valid, other port takes over without idle
    do_reset();
    q0 = '{8'h40, 8'h41};
    q1 = '{8'h50, 8'h51, 8'h52};
    en0 = 1; en1 = 1;
    run_until("t4", 5, 30);
    e = '{8'h40, 8'h41, 8'h50, 8'h51, 8'h52};
    chk_seq("t4_data");
    if (out_cyc.size() >= 5) begin
      chk("t4_switch_gap", out_cyc[2] - out_cyc[1], 2);
      chk("t4_in1_run", out_cyc[4] - out_cyc[2], 2);
    end

    // 5: reset mid-burst, then first tie goes to in0
    do_reset();
    for (int i = 0; i < 6; i++) q1.push_back(8'(8'h60 + i));
    en1 = 1;
    run_until("t5a", 1, 20);
    chk("t5_pre_valid", out_valid, 1);
    do_reset();
    q0 = '{8'h70, 8'h71};
    q1 = '{8'h80, 8'h81};
    en0 = 1; en1 = 1;
    run_until("t5b", 4, 30);
    e = '{8'h70, 8'h71, 8'h80, 8'h81};
    chk_seq("t5_data");

    // random traffic with random backpressure
    do_reset();
    en0 = 1; en1 = 1; pushed = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 30) begin q0.push_back(8'($urandom)); pushed++; end
      if ($urandom_range(0, 99) < 30) begin q1.push_back(8'($urandom)); pushed++; end
      ordy = ($urandom_range(0, 99) < 70);
      step();
    end
    ordy = 1; g = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && g < 3000) begin
      step(); g++;
    end
    chk("rnd_drained", exp_q.size() + q0.size() + q1.size(), 0);
    chk("rnd_count", outs.size(), pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit 2:1 mux datapath between two valid/ready requesters.
- Drives the mux select and registers the selected word into a single-stage output buffer with valid/ready.
- Bounds consecutive grants per requester so neither port can starve the other.
- Sits between two producers and one downstream consumer.

Parameters:
WIDTH, 8, data width of both inputs and the output.
HOLD_MAX, 4, max consecutive transfers granted to one requester while the other is requesting (legal range 1..15).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
in0_data  input  WIDTH  requester 0 word.
in0_valid  input  1  requester 0 has a word.
in0_ready  output  1  requester 0 word accepted this cycle.
in1_data  input  WIDTH  requester 1 word.
in1_valid  input  1  requester 1 has a word.
in1_ready  output  1  requester 1 word accepted this cycle.
out_data  output  WIDTH  registered output word.
out_valid  output  1  out_data holds a word.
out_ready  input  1  downstream accepts out_data.
sel  output  1  mux select; 1 = in0, 0 = in1 (registered).

Behaviour:
- Reset (sync, clk edge with reset=1): state=IDLE, out_valid=0, out_data=0, sel=0, last_served=1 (in0 wins first tie), hold_cnt=0, in0_ready=in1_ready=0. Reset overrides all other activity, including a burst mid-transfer; any in-flight out word is dropped.
- load_en = !out_valid | out_ready.
- Transfer on port k = ink_valid & ink_ready.
- State IDLE:
  - in0_ready = in1_ready = 0.
  - Next state: both valid -> GRANT of !last_served; one valid -> GRANT of that port; none -> IDLE.
  - sel updates with the grant and holds its last value while IDLE.
- State GRANTk:
  - ink_ready = load_en; the other port's ready = 0.
  - On transfer: out_data <= mux(in0_data, in1_data, sel), out_valid <= 1, last_served <= k, hold_cnt++.
  - After a transfer with hold_cnt+1 == HOLD_MAX:
    - other port valid -> GRANT of other port, hold_cnt=0.
    - otherwise stay in GRANTk, hold_cnt=0.
  - ink_valid low:
    - other port valid -> GRANT of other port (no bubble).
    - otherwise -> IDLE, hold_cnt=0.
  - ink_valid high but load_en=0 (backpressure): stay in GRANTk, no count change, no switch.
- Output buffer:
  - If out_valid & out_ready and there is no new transfer: out_valid <= 0.
  - While out_valid & !out_ready: out_data and out_valid are held stable.
- Latency:
  - From IDLE: ink_valid rising at edge N -> grant at edge N+1 -> transfer in cycle N+1 -> out_valid at edge N+2.
  - In GRANTk with load_en=1: one word per cycle, latency 1.
- Simultaneous events:
  - A port switch due to hold limit and a transfer in the same cycle: the transfer completes on the old grant, and the new grant is effective next cycle.
  - Both valid from IDLE: alternate by last_served.
- Data must be stable while valid & !ready (requester obligation); the arbiter never drops or duplicates a word.

Test Plan:
1. in0 streams 0x10..0x15, in1 idle, out_ready=1 -> out_data 0x10..0x15 on consecutive cycles, first at 2 cycles after in0_valid; sel=1 throughout; no switch at HOLD_MAX.
2. After reset, in0 and in1 both valid from IDLE, HOLD_MAX=4, in0=0xA0+i, in1=0xB0+i -> out sequence A0,A1,A2,A3,B0,B1,B2,B3,A4...; sel toggles every 4 transfers.
3. Backpressure: in0 streaming, out_ready held 0 for 3 cycles -> out_data frozen, out_valid=1, in0_ready=0, hold_cnt unchanged; resumes with no loss or duplication.
4. in0 burst with in1 valid; in0_valid drops after 2 words -> grant switches to in1 the next cycle with no IDLE bubble; in1 words follow directly.
5. reset asserted mid-burst (out_valid=1, GRANT1) -> next edge: out_valid=0, out_data=0, sel=0, in*_ready=0; first post-reset tie is granted to in0.
6. Both idle after traffic -> IDLE within 1 cycle, sel holds last value, out_valid falls after out_ready handshake.
